uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/loader_pkg.sv | 18 +
 rtl/uart_loader_if.sv | 26 ++
 rtl/word_assembler.sv | 48 ++++
 rtl/uart_loader.sv | 205 ++++++++++++++++++++
 tb/tb_uart_loader.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and default handshake bytes for the UART loader
package loader_pkg;

    typedef enum logic [2:0] {
        HELLO,
        SIZE,
        PROG,
        CSUM,
        ACK,
        DATA,
        ERR
    } state_t;

    localparam logic [7:0] HELLO_BYTE_DEFAULT = 8'h99;
    localparam logic [7:0] DONE_BYTE_DEFAULT  = 8'hAA;
    localparam logic [7:0] NAK_BYTE_DEFAULT   = 8'h55;

endpackage

// File: rtl/uart_loader_if.sv
// rtl/uart_loader_if.sv - byte receive, byte send and word output signal bundle of the loader
interface uart_loader_if #(
    parameter int WORD_BYTES = 4
);
    logic                    rx_valid;
    logic [7:0]              rx_data;
    logic                    tx_busy;
    logic                    tx_start;
    logic [7:0]              tx_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_kind;
    logic [8*WORD_BYTES-1:0] out_data;

    // Loader side: consumes received bytes, produces send strobes and words.
    modport master (
        input  rx_valid, rx_data, tx_busy, out_ready,
        output tx_start, tx_data, out_valid, out_kind, out_data
    );

    // Environment side: UART receiver/sender and word consumer.
    modport slave (
        output rx_valid, rx_data, tx_busy, out_ready,
        input  tx_start, tx_data, out_valid, out_kind, out_data
    );
endinterface

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - little-endian byte-to-word packer with early flush
module word_assembler #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    strobe,
    input  logic                    flush,
    input  logic [7:0]              byte_in,
    output logic [8*WORD_BYTES-1:0] word,
    output logic                    done
);
    localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [8*WORD_BYTES-1:0] acc;
    logic [CW-1:0]           fill;

    // The word presented on a completing strobe already contains the incoming
    // byte, so the parent can register it on the same edge. Unfilled lanes
    // stay zero because acc is cleared after every completed word.
    always_comb begin
        word = acc;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (strobe && fill == CW'(i)) begin
                word[8*i +: 8] = byte_in;
            end
        end
    end

    assign done = strobe && (flush || fill == CW'(WORD_BYTES - 1));

    // Accumulate bytes; restart from an empty word after each completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc  <= '0;
            fill <= '0;
        end else if (strobe) begin
            if (done) begin
                acc  <= '0;
                fill <= '0;
            end else begin
                acc  <= word;
                fill <= fill + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - serial program/data loader: hello, size, program words, checksum, data words
module uart_loader
    import loader_pkg::*;
#(
    parameter int         WORD_BYTES = 4,
    parameter logic [7:0] HELLO_BYTE = HELLO_BYTE_DEFAULT,
    parameter logic [7:0] DONE_BYTE  = DONE_BYTE_DEFAULT,
    parameter logic [7:0] NAK_BYTE   = NAK_BYTE_DEFAULT,
    parameter bit         CSUM_EN    = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_kind,
    output logic [8*WORD_BYTES-1:0] out_data,
    output logic                    program_loaded,
    output logic                    error,
    output logic [15:0]             led
);
    localparam int W = 8 * WORD_BYTES;

    state_t        state, state_n;
    logic [23:0]   size_buf, size_buf_n;
    logic [1:0]    size_idx, size_idx_n;
    logic [31:0]   prog_left, prog_left_n;
    logic [7:0]    csum, csum_n;
    logic          nak_pend, nak_pend_n;
    logic [15:0]   led_n;
    logic          out_valid_n, out_kind_n;
    logic [W-1:0]  out_data_n;
    logic          program_loaded_n, error_n;

    logic          asm_strobe, asm_flush, asm_done;
    logic [W-1:0]  asm_word;
    logic          overrun;
    logic [31:0]   size_full;

    assign asm_strobe = rx_valid && (state == PROG || state == DATA);
    assign asm_flush  = (state == PROG) && (prog_left == 32'd1);
    // A word completing while the previous one is still refused is lost.
    assign overrun    = asm_done && out_valid && !out_ready;
    assign size_full  = {rx_data, size_buf};

    word_assembler #(
        .WORD_BYTES(WORD_BYTES)
    ) u_asm (
        .clock   (clock),
        .reset   (reset),
        .strobe  (asm_strobe),
        .flush   (asm_flush),
        .byte_in (rx_data),
        .word    (asm_word),
        .done    (asm_done)
    );

    // Next-state, datapath updates and the combinational send strobe.
    always_comb begin
        state_n          = state;
        size_buf_n       = size_buf;
        size_idx_n       = size_idx;
        prog_left_n      = prog_left;
        csum_n           = csum;
        nak_pend_n       = nak_pend;
        led_n            = led;
        out_valid_n      = out_valid;
        out_kind_n       = out_kind;
        out_data_n       = out_data;
        program_loaded_n = program_loaded;
        error_n          = error;
        tx_start         = 1'b0;
        tx_data          = 8'h00;

        if (out_valid && out_ready) begin
            out_valid_n = 1'b0;
        end
        if (asm_done && !overrun) begin
            out_valid_n = 1'b1;
            out_data_n  = asm_word;
            out_kind_n  = (state == DATA);
        end

        case (state)
            HELLO: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    tx_data  = HELLO_BYTE;
                    state_n  = SIZE;
                end
            end
            SIZE: begin
                if (rx_valid) begin
                    size_idx_n = size_idx + 2'd1;
                    case (size_idx)
                        2'd0: size_buf_n[7:0]   = rx_data;
                        2'd1: size_buf_n[15:8]  = rx_data;
                        2'd2: size_buf_n[23:16] = rx_data;
                        default: begin
                            prog_left_n = size_full;
                            led_n       = size_full[15:0];
                            size_buf_n  = '0;
                            if (size_full != 32'd0) begin
                                state_n = PROG;
                            end else if (CSUM_EN) begin
                                state_n = CSUM;
                            end else begin
                                state_n = ACK;
                            end
                        end
                    endcase
                end
            end
            PROG: begin
                if (rx_valid) begin
                    prog_left_n = prog_left - 32'd1;
                    csum_n      = csum ^ rx_data;
                    if (overrun) begin
                        error_n = 1'b1;
                        state_n = ERR;
                    end else if (prog_left == 32'd1) begin
                        state_n = CSUM_EN ? CSUM : ACK;
                    end
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum) begin
                        state_n = ACK;
                    end else begin
                        nak_pend_n = 1'b1;
                        error_n    = 1'b1;
                        state_n    = ERR;
                    end
                end
            end
            ACK: begin
                if (!tx_busy) begin
                    tx_start         = 1'b1;
                    tx_data          = DONE_BYTE;
                    program_loaded_n = 1'b1;
                    state_n          = DATA;
                end
            end
            DATA: begin
                if (overrun) begin
                    error_n = 1'b1;
                    state_n = ERR;
                end
            end
            ERR: begin
                // The only transmission allowed here is the one pending NAK.
                if (nak_pend && !tx_busy) begin
                    tx_start   = 1'b1;
                    tx_data    = NAK_BYTE;
                    nak_pend_n = 1'b0;
                end
            end
            default: begin
                state_n = HELLO;
            end
        endcase

        if (reset) begin
            tx_start = 1'b0;
            tx_data  = 8'h00;
        end
    end

    // State and datapath registers; reset aborts any transfer in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= HELLO;
            size_buf       <= '0;
            size_idx       <= '0;
            prog_left      <= '0;
            csum           <= '0;
            nak_pend       <= 1'b0;
            led            <= 16'hFFFF;
            out_valid      <= 1'b0;
            out_kind       <= 1'b0;
            out_data       <= '0;
            program_loaded <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= state_n;
            size_buf       <= size_buf_n;
            size_idx       <= size_idx_n;
            prog_left      <= prog_left_n;
            csum           <= csum_n;
            nak_pend       <= nak_pend_n;
            led            <= led_n;
            out_valid      <= out_valid_n;
            out_kind       <= out_kind_n;
            out_data       <= out_data_n;
            program_loaded <= program_loaded_n;
            error          <= error_n;
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - scoreboard bench for uart_loader
module tb_uart_loader;
    localparam int WB = 4;

    typedef struct packed {
        logic        kind;
        logic [31:0] data;
    } word_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    // 100 MHz style clock.
    always #5 clock = ~clock;

    uart_loader_if #(.WORD_BYTES(WB)) bus ();

    logic        program_loaded, error;
    logic [15:0] led;

    logic        rx_valid1;
    logic [7:0]  rx_data1;
    logic        tx_start1;
    logic [7:0]  tx_data1;
    logic        out_valid1, out_kind1;
    logic [31:0] out_data1;
    logic        program_loaded1, error1;
    logic [15:0] led1;

    uart_loader #(.WORD_BYTES(WB)) dut (
        .clock          (clock),
        .reset          (reset),
        .rx_valid       (bus.rx_valid),
        .rx_data        (bus.rx_data),
        .tx_busy        (bus.tx_busy),
        .tx_start       (bus.tx_start),
        .tx_data        (bus.tx_data),
        .out_valid      (bus.out_valid),
        .out_ready      (bus.out_ready),
        .out_kind       (bus.out_kind),
        .out_data       (bus.out_data),
        .program_loaded (program_loaded),
        .error          (error),
        .led            (led)
    );

    uart_loader #(.WORD_BYTES(WB), .CSUM_EN(1'b0)) dut1 (
        .clock          (clock),
        .reset          (reset),
        .rx_valid       (rx_valid1),
        .rx_data        (rx_data1),
        .tx_busy        (1'b0),
        .tx_start       (tx_start1),
        .tx_data        (tx_data1),
        .out_valid      (out_valid1),
        .out_ready      (1'b1),
        .out_kind       (out_kind1),
        .out_data       (out_data1),
        .program_loaded (program_loaded1),
        .error          (error1),
        .led            (led1)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_tx0[$];
    logic [7:0] exp_tx1[$];
    word_t      exp_w0[$];
    logic       prev_tx0 = 1'b0;
    logic       prev_tx1 = 1'b0;
    word_t      w0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: actual=%0h expected=nothing", name, act);
    endtask

    // Monitor for the checksum-enabled loader: send strobes and accepted words.
    always @(negedge clock) begin
        if (bus.tx_start) begin
            check("tx0_while_busy", {63'd0, bus.tx_busy}, 64'd0);
            check("tx0_back_to_back", {63'd0, prev_tx0}, 64'd0);
            if (exp_tx0.size() == 0) unexpected("tx0_unexpected", {56'd0, bus.tx_data});
            else check("tx0_byte", {56'd0, bus.tx_data}, {56'd0, exp_tx0.pop_front()});
        end
        prev_tx0 = bus.tx_start;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_w0.size() == 0) begin
                unexpected("word0_unexpected", {31'd0, bus.out_kind, bus.out_data});
            end else begin
                w0 = exp_w0.pop_front();
                check("word0", {31'd0, bus.out_kind, bus.out_data}, {31'd0, w0});
            end
        end
    end

    // Monitor for the checksum-disabled loader.
    always @(negedge clock) begin
        if (tx_start1) begin
            check("tx1_back_to_back", {63'd0, prev_tx1}, 64'd0);
            if (exp_tx1.size() == 0) unexpected("tx1_unexpected", {56'd0, tx_data1});
            else check("tx1_byte", {56'd0, tx_data1}, {56'd0, exp_tx1.pop_front()});
        end
        prev_tx1 = tx_start1;
        if (out_valid1) unexpected("word1_unexpected", {31'd0, out_kind1, out_data1});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send0(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b);
        rx_valid1 = 1'b1;
        rx_data1  = b;
        tick();
        rx_valid1 = 1'b0;
    endtask

    task automatic size0(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send0(n[8*i +: 8]);
    endtask

    task automatic size1(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send1(n[8*i +: 8]);
    endtask

    task automatic drained(input string name);
        check({name, "_tx0_left"}, 64'(exp_tx0.size()), 64'd0);
        check({name, "_tx1_left"}, 64'(exp_tx1.size()), 64'd0);
        check({name, "_word0_left"}, 64'(exp_w0.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        rx_valid1    = 1'b0;
        tick();
        tick();
        check("rst_led", {48'd0, led}, 64'hFFFF);
        check("rst_led1", {48'd0, led1}, 64'hFFFF);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_out_data", {32'd0, bus.out_data}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        check("rst_loaded", {63'd0, program_loaded}, 64'd0);
        check("rst_tx_start", {63'd0, bus.tx_start}, 64'd0);
        exp_tx0.push_back(8'h99);
        exp_tx1.push_back(8'h99);
        reset = 1'b0;
    endtask

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.tx_busy   = 1'b0;
        bus.out_ready = 1'b1;
        rx_valid1     = 1'b0;
        rx_data1      = 8'h00;

        // Hello after reset, then an 8-byte program in two full words.
        do_reset();
        tick();
        tick();
        check("hello_within_2", 64'(exp_tx0.size()), 64'd0);
        size0(32'd8);
        exp_w0.push_back({1'b0, 32'h04030201});
        exp_w0.push_back({1'b0, 32'h08070605});
        for (int i = 1; i <= 8; i++) send0(8'(i));
        exp_tx0.push_back(8'hAA);
        send0(8'h08);
        tick(); tick(); tick();
        check("a_loaded", {63'd0, program_loaded}, 64'd1);
        check("a_led", {48'd0, led}, 64'h0008);
        check("a_error", {63'd0, error}, 64'd0);
        drained("a");

        // Byte during HELLO is discarded; 6-byte program ends in a partial word; data words.
        do_reset();
        send0(8'hEE);
        size0(32'd6);
        exp_w0.push_back({1'b0, 32'h14131211});
        exp_w0.push_back({1'b0, 32'h00001615});
        for (int i = 8'h11; i <= 8'h16; i++) send0(8'(i));
        exp_tx0.push_back(8'hAA);
        send0(8'h07);
        tick(); tick(); tick();
        check("b_loaded", {63'd0, program_loaded}, 64'd1);
        check("b_led", {48'd0, led}, 64'h0006);
        exp_w0.push_back({1'b1, 32'hA3A2A1A0});
        for (int i = 8'hA0; i <= 8'hA5; i++) send0(8'(i));
        tick(); tick();
        check("b_error", {63'd0, error}, 64'd0);
        drained("b");

        // Hello held off by tx_busy; wrong checksum gives NAK and a dead loader.
        bus.tx_busy = 1'b1;
        do_reset();
        send0(8'hEE);
        tick(); tick(); tick();
        check("c_hello_waits_busy", 64'(exp_tx0.size()), 64'd1);
        bus.tx_busy = 1'b0;
        tick();
        size0(32'd4);
        exp_w0.push_back({1'b0, 32'h24232221});
        for (int i = 8'h21; i <= 8'h24; i++) send0(8'(i));
        exp_tx0.push_back(8'h55);
        send0(8'h05);
        tick(); tick();
        check("c_error", {63'd0, error}, 64'd1);
        check("c_loaded", {63'd0, program_loaded}, 64'd0);
        for (int i = 8'h51; i <= 8'h58; i++) send0(8'(i));
        tick(); tick();
        check("c_no_out_valid", {63'd0, bus.out_valid}, 64'd0);
        drained("c");

        // Overrun: second word completes while the first is still refused.
        do_reset();
        tick();
        bus.out_ready = 1'b0;
        size0(32'd8);
        exp_w0.push_back({1'b0, 32'h34333231});
        for (int i = 8'h31; i <= 8'h38; i++) send0(8'(i));
        tick();
        check("d1_overrun_error", {63'd0, error}, 64'd1);
        bus.out_ready = 1'b1;
        tick(); tick();
        check("d1_loaded", {63'd0, program_loaded}, 64'd0);
        drained("d1");

        // Acceptance in the completing cycle is not an overrun.
        do_reset();
        tick();
        bus.out_ready = 1'b0;
        size0(32'd8);
        exp_w0.push_back({1'b0, 32'h44434241});
        exp_w0.push_back({1'b0, 32'h48474645});
        for (int i = 8'h41; i <= 8'h47; i++) send0(8'(i));
        bus.out_ready = 1'b1;
        send0(8'h48);
        exp_tx0.push_back(8'hAA);
        send0(8'h08);
        tick(); tick(); tick();
        check("d2_error", {63'd0, error}, 64'd0);
        check("d2_loaded", {63'd0, program_loaded}, 64'd1);
        drained("d2");

        // Checksum disabled: size 0 acknowledges straight away.
        do_reset();
        tick();
        exp_tx1.push_back(8'hAA);
        size1(32'd0);
        tick();
        check("e_ack_after_size", 64'(exp_tx1.size()), 64'd0);
        check("e_loaded1", {63'd0, program_loaded1}, 64'd1);
        check("e_error1", {63'd0, error1}, 64'd0);

        // Reset in the middle of a program restarts with hello.
        do_reset();
        tick();
        size1(32'd16);
        send1(8'h01);
        send1(8'h02);
        send1(8'h03);
        check("f_led1_size", {48'd0, led1}, 64'h0010);
        check("f_loaded1", {63'd0, program_loaded1}, 64'd0);
        do_reset();
        tick(); tick();
        check("f_led1_after", {48'd0, led1}, 64'hFFFF);
        drained("f");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
